usb_rx_crc16_check: RTL and testbench

Receive-side DATA-packet CRC16 checker. It sits between the RX packet decoder (PID already stripped) and the endpoint buffer logic. It runs the USB CRC16 over every byte of the data field, including the two trailing CRC bytes, and strips those two bytes from the forwarded stream. At end of packet it reports pass/fail, the payload length and any length/abort errors.

---
 rtl/usb_rx_crc16_check.sv | 185 ++++++++++++++++++
 tb/tb_usb_rx_crc16_check.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_crc16_check.sv
// USB receive-side DATA packet CRC16 checker.
// Runs the USB CRC16 over the whole data field (payload plus the two CRC
// bytes), forwards only the payload using a two-byte holding pipeline, and
// reports the packet status with a one-cycle done pulse.
module usb_rx_crc16_check #(
  parameter logic [15:0] RESIDUE = 16'h800D,
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sop_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        eop_i,
  input  logic        abort_i,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  output logic        done_o,
  output logic        crc_ok_o,
  output logic        err_short_o,
  output logic        err_len_o,
  output logic        err_abort_o,
  output logic [10:0] len_o,
  output logic        busy_o
);

  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1, STREAM} state_t;

  state_t      state_q;
  logic [15:0] crc_q;
  logic [11:0] cnt_q;
  logic        len_err_q;
  logic [7:0]  slot_a_q;
  logic [7:0]  slot_b_q;

  logic [7:0]  out_data_q;
  logic        out_valid_q;
  logic        done_q;
  logic        crc_ok_q;
  logic        err_short_q;
  logic        err_len_q;
  logic        err_abort_q;
  logic [10:0] len_q;
  logic        busy_q;

  logic [15:0] crc_d;
  logic [15:0] crc_sop_d;
  logic [11:0] cnt_d;
  logic [11:0] pay_d;
  logic [11:0] pay_cur;
  logic        len_err_d;

  // One byte of CRC16 (poly 0x8005), data bit 0 shifted in first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[15] ^ d[k]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Payload counts wider than the length port are clamped rather than wrapped.
  function automatic logic [10:0] len_sat(input logic [11:0] p);
    return (p > 12'd2047) ? 11'h7FF : p[10:0];
  endfunction

  // Next CRC, byte count and sticky length error if the current byte is accepted.
  always_comb begin
    crc_d     = crc_step(crc_q, data_i);
    crc_sop_d = crc_step(16'hFFFF, data_i);
    cnt_d     = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
    pay_d     = (cnt_d >= 12'd2) ? cnt_d - 12'd2 : 12'd0;
    pay_cur   = (cnt_q >= 12'd2) ? cnt_q - 12'd2 : 12'd0;
    len_err_d = len_err_q | (pay_d > MAX_LEN_W);
  end

  // Packet FSM, holding pipeline and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= 16'hFFFF;
      cnt_q       <= 12'd0;
      len_err_q   <= 1'b0;
      slot_a_q    <= 8'd0;
      slot_b_q    <= 8'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      err_short_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_abort_q <= 1'b0;
      len_q       <= 11'd0;
      busy_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (valid_i && sop_i) begin
          crc_q     <= crc_sop_d;
          slot_a_q  <= data_i;
          cnt_q     <= 12'd1;
          len_err_q <= 1'b0;
          if (eop_i) begin
            // Single-byte packet: cannot even hold a CRC.
            done_q      <= 1'b1;
            crc_ok_q    <= 1'b0;
            err_short_q <= 1'b1;
            err_len_q   <= 1'b0;
            err_abort_q <= 1'b0;
            len_q       <= 11'd0;
          end else begin
            state_q <= HOLD1;
            busy_q  <= 1'b1;
          end
        end
      end else if (abort_i || (valid_i && sop_i)) begin
        // Abort, or a new sop without the old eop: close the old packet as aborted.
        done_q      <= 1'b1;
        crc_ok_q    <= 1'b0;
        err_short_q <= 1'b0;
        err_len_q   <= len_err_q;
        err_abort_q <= 1'b1;
        len_q       <= len_sat(pay_cur);
        if (!abort_i && !eop_i) begin
          // Restart on the new sop byte in the same cycle.
          crc_q     <= crc_sop_d;
          slot_a_q  <= data_i;
          cnt_q     <= 12'd1;
          len_err_q <= 1'b0;
          state_q   <= HOLD1;
        end else begin
          // A single-byte packet overlapping the restart is dropped with the old one.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else if (valid_i) begin
        crc_q     <= crc_d;
        cnt_q     <= cnt_d;
        len_err_q <= len_err_d;
        case (state_q)
          HOLD0: begin
            slot_a_q <= data_i;
            state_q  <= HOLD1;
          end
          HOLD1: begin
            slot_b_q <= data_i;
            state_q  <= STREAM;
          end
          default: begin
            out_data_q  <= slot_a_q;
            out_valid_q <= 1'b1;
            slot_a_q    <= slot_b_q;
            slot_b_q    <= data_i;
          end
        endcase
        if (eop_i) begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          err_short_q <= (cnt_d < 12'd2);
          crc_ok_q    <= (crc_d == RESIDUE) && !len_err_d && (cnt_d >= 12'd2);
          err_len_q   <= len_err_d;
          err_abort_q <= 1'b0;
          len_q       <= (cnt_d < 12'd2) ? 11'd0 : len_sat(pay_d);
        end
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign done_o      = done_q;
  assign crc_ok_o    = crc_ok_q;
  assign err_short_o = err_short_q;
  assign err_len_o   = err_len_q;
  assign err_abort_o = err_abort_q;
  assign len_o       = len_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_usb_rx_crc16_check.sv
// Self-checking bench for usb_rx_crc16_check (MAX_LEN reduced to 16).
module tb_usb_rx_crc16_check;
  localparam int MAX_LEN = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        ok;
    logic        sh;
    logic        ln;
    logic        ab;
    logic [10:0] len;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sop_i = 1'b0;
  logic [7:0]  data_i = 8'd0;
  logic        valid_i = 1'b0;
  logic        eop_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        done_o;
  logic        crc_ok_o;
  logic        err_short_o;
  logic        err_len_o;
  logic        err_abort_o;
  logic [10:0] len_o;
  logic        busy_o;

  int   chk_cnt = 0;
  int   pass_cnt = 0;
  bq_t  got_q;
  res_t res_q[$];

  usb_rx_crc16_check #(.RESIDUE(16'h800D), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .sop_i(sop_i), .data_i(data_i), .valid_i(valid_i),
    .eop_i(eop_i), .abort_i(abort_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .done_o(done_o), .crc_ok_o(crc_ok_o), .err_short_o(err_short_o), .err_len_o(err_len_o),
    .err_abort_o(err_abort_o), .len_o(len_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Collect forwarded bytes and end-of-packet reports between clock edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_o) got_q.push_back(out_data_o);
      if (done_o) res_q.push_back('{crc_ok_o, err_short_o, err_len_o, err_abort_o, len_o});
    end
  end

  // Reference CRC over a whole byte list, bit 0 of each byte first.
  function automatic logic [15:0] crc16(input bq_t b);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) for (int k = 0; k < 8; k++)
      c = (c[15] ^ b[i][k]) ? ((c << 1) ^ 16'h8005) : (c << 1);
    return c;
  endfunction

  // Payload followed by the inverted CRC, register MSB first on the wire.
  function automatic bq_t with_crc(input bq_t p);
    bq_t r = p;
    logic [15:0] c = crc16(p);
    logic [7:0] b0, b1;
    for (int k = 0; k < 8; k++) begin
      b0[k] = ~c[15-k];
      b1[k] = ~c[7-k];
    end
    r.push_back(b0);
    r.push_back(b1);
    return r;
  endfunction

  // Expected report for a packet of the given bytes (ended by eop or abort).
  function automatic res_t model_res(input bq_t b, input bit aborted);
    res_t r;
    int n = b.size();
    int pay = (n >= 2) ? n - 2 : 0;
    r.ab  = aborted;
    r.sh  = !aborted && (n < 2);
    r.ln  = (pay > MAX_LEN);
    r.len = 11'(pay);
    r.ok  = !aborted && !r.sh && !r.ln && (crc16(b) == 16'h800D);
    return r;
  endfunction

  // Bytes expected on the output: everything except the last two accepted.
  function automatic bq_t model_fwd(input bq_t b);
    bq_t r;
    for (int i = 0; i + 2 < b.size(); i++) r.push_back(b[i]);
    return r;
  endfunction

  function automatic bit fwd_match(input bq_t exp);
    bit m = (got_q.size() == exp.size());
    for (int i = 0; m && i < exp.size(); i++) if (got_q[i] !== exp[i]) m = 0;
    return m;
  endfunction

  task automatic send_bytes(input bq_t b, input bit with_eop);
    for (int i = 0; i < b.size(); i++) begin
      valid_i = 1'b1;
      sop_i   = (i == 0);
      eop_i   = with_eop && (i == b.size() - 1);
      data_i  = b[i];
      @(posedge clk); #1;
    end
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = 8'd0;
  endtask

  task automatic wait_results(input int n);
    for (int c = 0; c < 20 && res_q.size() < n; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    res_q.delete();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #2;
    chk_cnt++;
    if ({out_data_o, out_valid_o, done_o, crc_ok_o, err_short_o, err_len_o, err_abort_o, len_o, busy_o} !== 26'd0)
      $display("FAIL reset_outputs: got %h want 0", {out_data_o, out_valid_o, done_o, crc_ok_o,
               err_short_o, err_len_o, err_abort_o, len_o, busy_o});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy_o, done_o);
    else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_packet(input string name, input bq_t pkt);
    res_t e = model_res(pkt, 1'b0);
    clear_obs();
    send_bytes(pkt, 1'b1);
    wait_results(1);
    chk_cnt++;
    if (res_q.size() != 1) $display("FAIL %s_done: got %0d reports want 1", name, res_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (res_q.size() == 0 || res_q[0] !== e)
      $display("FAIL %s_report: got %h want %h", name, (res_q.size() != 0) ? res_q[0] : 15'h7FFF, e);
    else pass_cnt++;
    chk_cnt++;
    if (!fwd_match(model_fwd(pkt))) $display("FAIL %s_fwd: got %0d bytes want %0d", name, got_q.size(), model_fwd(pkt).size());
    else pass_cnt++;
    $display("%s: %0d bytes ok=%b sh=%b ln=%b len=%0d", name, pkt.size(), e.ok, e.sh, e.ln, e.len);
  endtask

  task automatic test_zero_len();
    bq_t p = '{8'h00, 8'h00};
    test_packet("zero_len", p);
    chk_cnt++;
    if (res_q.size() == 0 || res_q[0] !== 15'h4000) $display("FAIL zero_len_const: got %h want 4000", (res_q.size() != 0) ? res_q[0] : 15'h7FFF);
    else pass_cnt++;
  endtask

  task automatic test_good_and_flip();
    bq_t p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    bq_t pk = with_crc(p);
    test_packet("good8", pk);
    chk_cnt++;
    if (res_q.size() == 0 || res_q[0] !== {1'b1, 3'b000, 11'd8}) $display("FAIL good8_const: got %h want %h", (res_q.size() != 0) ? res_q[0] : 15'h7FFF, {1'b1, 3'b000, 11'd8});
    else pass_cnt++;
    pk[2][0] = ~pk[2][0];
    test_packet("flip8", pk);
    chk_cnt++;
    if (res_q.size() == 0 || res_q[0] !== {1'b0, 3'b000, 11'd8}) $display("FAIL flip8_const: got %h want %h", (res_q.size() != 0) ? res_q[0] : 15'h7FFF, {1'b0, 3'b000, 11'd8});
    else pass_cnt++;
  endtask

  task automatic test_short_and_len();
    bq_t one = '{8'hA5};
    bq_t p;
    test_packet("single", one);
    for (int i = 0; i < MAX_LEN + 1; i++) p.push_back(8'($urandom));
    test_packet("too_long", with_crc(p));
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      bq_t p, pk;
      int n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      pk = with_crc(p);
      if ($urandom_range(0, 2) == 0) begin
        int j = $urandom_range(0, pk.size() - 1);
        pk[j] = pk[j] ^ (8'd1 << $urandom_range(0, 7));
      end
      test_packet("random", pk);
    end
  endtask

  task automatic test_abort();
    bq_t p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    res_t e = model_res(p, 1'b1);
    clear_obs();
    send_bytes(p, 1'b0);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    wait_results(1);
    chk_cnt++;
    if (res_q.size() != 1 || res_q[0] !== e || e !== {1'b0, 3'b001, 11'd3})
      $display("FAIL abort_report: got %0d reports %h want %h", res_q.size(), (res_q.size() != 0) ? res_q[0] : 15'h7FFF, e);
    else pass_cnt++;
    chk_cnt++;
    if (!fwd_match(model_fwd(p))) $display("FAIL abort_fwd: got %0d bytes want 3", got_q.size());
    else pass_cnt++;
    clear_obs();
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    wait_results(1);
    chk_cnt++;
    if (res_q.size() != 0) $display("FAIL abort_idle: got %0d reports want 0", res_q.size());
    else pass_cnt++;
    $display("abort: len=%0d", e.len);
  endtask

  task automatic test_sop_restart();
    bq_t a = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    bq_t p = '{8'h9A, 8'hBC, 8'hDE};
    bq_t b = with_crc(p);
    bq_t fwd = model_fwd(a);
    res_t ea = model_res(a, 1'b1);
    res_t eb = model_res(b, 1'b0);
    foreach (p[i]) fwd.push_back(p[i]);
    clear_obs();
    send_bytes(a, 1'b0);
    send_bytes(b, 1'b1);
    wait_results(2);
    chk_cnt++;
    if (res_q.size() != 2 || res_q[0] !== ea || res_q[1] !== eb)
      $display("FAIL sop_restart_report: got %0d reports want %h then %h", res_q.size(), ea, eb);
    else pass_cnt++;
    chk_cnt++;
    if (!fwd_match(fwd)) $display("FAIL sop_restart_fwd: got %0d bytes want %0d", got_q.size(), fwd.size());
    else pass_cnt++;
    $display("sop_restart: reports=%0d", res_q.size());
  endtask

  task automatic test_mid_reset();
    bq_t a = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(a, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({out_data_o, out_valid_o, done_o, crc_ok_o, err_short_o, err_len_o, err_abort_o, len_o, busy_o} !== 26'd0)
      $display("FAIL mid_reset_outputs: got %h want 0", {out_data_o, out_valid_o, done_o, crc_ok_o,
               err_short_o, err_len_o, err_abort_o, len_o, busy_o});
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_obs();
    wait_results(1);
    chk_cnt++;
    if (res_q.size() != 0 || got_q.size() != 0 || busy_o !== 1'b0)
      $display("FAIL mid_reset_quiet: got %0d reports %0d bytes busy=%b want 0 0 0", res_q.size(), got_q.size(), busy_o);
    else pass_cnt++;
    $display("mid_reset: done");
  endtask

  task automatic test_back_to_back();
    bq_t p1 = '{8'h10, 8'h20, 8'h30};
    bq_t p2 = '{8'h40, 8'h50};
    bq_t a = with_crc(p1);
    bq_t b = with_crc(p2);
    bq_t fwd = p1;
    foreach (p2[i]) fwd.push_back(p2[i]);
    clear_obs();
    send_bytes(a, 1'b1);
    send_bytes(b, 1'b1);
    wait_results(2);
    chk_cnt++;
    if (res_q.size() != 2 || res_q[0] !== {1'b1, 3'b000, 11'd3} || res_q[1] !== {1'b1, 3'b000, 11'd2})
      $display("FAIL back_to_back_report: got %0d reports want 2 good (len 3, 2)", res_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (!fwd_match(fwd)) $display("FAIL back_to_back_fwd: got %0d bytes want %0d", got_q.size(), fwd.size());
    else pass_cnt++;
    $display("back_to_back: reports=%0d", res_q.size());
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_good_and_flip();
    test_short_and_len();
    test_random();
    test_abort();
    test_sop_restart();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
